// File: rtl/counter_pkg.sv
// Shared types for the up/down count direction decoder: FSM states,
// step classes and the default observed-count width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRIMED,
    UP,
    DN
  } state_t;

  typedef enum logic [1:0] {
    STEP_UP,
    STEP_DN,
    STEP_BAD
  } step_t;

endpackage

// File: rtl/step_classify.sv
// Combinational classification of one counter step (prev -> count) as
// up, down or illegal, plus detection of the wrap-around steps.
module step_classify
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count,
  output step_t            step_class,
  output logic             wrap_up,
  output logic             wrap_dn
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] delta;

  always_comb begin
    // Modular difference: +1 is an up step, all-ones (-1) a down step.
    delta = count - prev;
    if (delta == ONE) begin
      step_class = STEP_UP;
    end else if (delta == MAX_VAL) begin
      step_class = STEP_DN;
    end else begin
      step_class = STEP_BAD;
    end
    wrap_up = (step_class == STEP_UP) && (prev == MAX_VAL) && (count == '0);
    wrap_dn = (step_class == STEP_DN) && (prev == '0) && (count == MAX_VAL);
  end

endmodule

// File: rtl/count_dir_decoder.sv
// Recovers the direction of an observed up/down counter, flags illegal
// steps and wraps, and keeps saturating run-length / reversal statistics.
module count_dir_decoder
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic             count_vld,
  input  logic             clr,
  output logic             up_dnb,
  output logic             dir_vld,
  output logic             step_err,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic [SAT_W-1:0] run_len,
  output logic [SAT_W-1:0] rev_cnt
);

  localparam logic [SAT_W-1:0] RUN_ONE = SAT_W'(1);

  state_t           state_reg;
  logic [WIDTH-1:0] prev_reg;
  step_t            step_class;
  logic             step_wrap_up;
  logic             step_wrap_dn;

  step_classify #(
    .WIDTH(WIDTH)
  ) u_step_classify (
    .prev      (prev_reg),
    .count     (count),
    .step_class(step_class),
    .wrap_up   (step_wrap_up),
    .wrap_dn   (step_wrap_dn)
  );

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
    return (v == '1) ? v : v + RUN_ONE;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      prev_reg  <= '0;
      up_dnb    <= 1'b0;
      dir_vld   <= 1'b0;
      step_err  <= 1'b0;
      wrap_up   <= 1'b0;
      wrap_dn   <= 1'b0;
      run_len   <= '0;
      rev_cnt   <= '0;
    end else begin
      step_err <= 1'b0;
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
      if (clr) begin
        // Clear wins over a coincident sample, which is dropped.
        state_reg <= IDLE;
        prev_reg  <= '0;
        up_dnb    <= 1'b0;
        dir_vld   <= 1'b0;
        run_len   <= '0;
        rev_cnt   <= '0;
      end else if (count_vld) begin
        prev_reg <= count;
        if (state_reg == IDLE) begin
          state_reg <= PRIMED;
        end else begin
          wrap_up <= step_wrap_up;
          wrap_dn <= step_wrap_dn;
          case (step_class)
            STEP_UP: begin
              state_reg <= UP;
              up_dnb    <= 1'b1;
              dir_vld   <= 1'b1;
              run_len   <= (state_reg == UP) ? sat_inc(run_len) : RUN_ONE;
              if (state_reg == DN) rev_cnt <= sat_inc(rev_cnt);
            end
            STEP_DN: begin
              state_reg <= DN;
              up_dnb    <= 1'b0;
              dir_vld   <= 1'b1;
              run_len   <= (state_reg == DN) ? sat_inc(run_len) : RUN_ONE;
              if (state_reg == UP) rev_cnt <= sat_inc(rev_cnt);
            end
            default: begin
              // up_dnb keeps its last value while re-priming.
              state_reg <= PRIMED;
              dir_vld   <= 1'b0;
              step_err  <= 1'b1;
              run_len   <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_count_dir_decoder.sv
// Randomized and directed self-checking bench for count_dir_decoder,
// compared against a step-by-step behavioural model of the decoder.
`timescale 1ns/1ps
module tb_count_dir_decoder;

  localparam int WIDTH = 4;
  localparam int SAT_W = 8;
  localparam int MODN  = 1 << WIDTH;
  localparam int SATM  = (1 << SAT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] count = '0;
  logic             count_vld = 1'b0;
  logic             clr = 1'b0;
  logic             up_dnb, dir_vld, step_err, wrap_up, wrap_dn;
  logic [SAT_W-1:0] run_len, rev_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  bit m_have;
  int m_prev;
  int m_dir;      // +1 up, -1 down, 0 no direction
  bit m_last_up;
  int m_run;
  int m_rev;
  bit m_err, m_wu, m_wd;

  count_dir_decoder #(.WIDTH(WIDTH), .SAT_W(SAT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .count_vld(count_vld),
    .clr      (clr),
    .up_dnb   (up_dnb),
    .dir_vld  (dir_vld),
    .step_err (step_err),
    .wrap_up  (wrap_up),
    .wrap_dn  (wrap_dn),
    .run_len  (run_len),
    .rev_cnt  (rev_cnt)
  );

  always #5 clk = ~clk;

  wire [20:0] dut_vec = {up_dnb, dir_vld, step_err, wrap_up, wrap_dn, run_len, rev_cnt};

  function automatic logic [20:0] exp_vec();
    return {m_last_up, (m_dir != 0), m_err, m_wu, m_wd, 8'(m_run), 8'(m_rev)};
  endfunction

  function automatic int sat(input int v);
    return (v > SATM) ? SATM : v;
  endfunction

  task automatic model_reset();
    m_have = 0; m_prev = 0; m_dir = 0; m_last_up = 0;
    m_run = 0; m_rev = 0; m_err = 0; m_wu = 0; m_wd = 0;
  endtask

  task automatic model_sample(input int c);
    int d;
    m_err = 0; m_wu = 0; m_wd = 0;
    if (!m_have) begin
      m_have = 1;
      m_prev = c;
      return;
    end
    d = (c - m_prev + MODN) % MODN;
    if (d == 1) begin
      m_wu = (m_prev == MODN - 1) && (c == 0);
      if (m_dir == 1) m_run = sat(m_run + 1);
      else begin
        if (m_dir == -1) m_rev = sat(m_rev + 1);
        m_run = 1;
      end
      m_dir = 1; m_last_up = 1;
    end else if (d == MODN - 1) begin
      m_wd = (m_prev == 0) && (c == MODN - 1);
      if (m_dir == -1) m_run = sat(m_run + 1);
      else begin
        if (m_dir == 1) m_rev = sat(m_rev + 1);
        m_run = 1;
      end
      m_dir = -1; m_last_up = 0;
    end else begin
      m_err = 1; m_dir = 0; m_run = 0;
    end
    m_prev = c;
  endtask

  // Drive one cycle and advance the model; outputs are sampled 1ns after the edge.
  task automatic cycle(input bit vld, input int c, input bit do_clr);
    count = c[WIDTH-1:0];
    count_vld = vld;
    clr = do_clr;
    @(posedge clk);
    #1;
    if (do_clr) model_reset();
    else if (vld) model_sample(c);
    else begin m_err = 0; m_wu = 0; m_wd = 0; end
    count_vld = 1'b0;
    clr = 1'b0;
    $display("t=%0t vld=%0b clr=%0b count=%0d -> up=%0b dv=%0b err=%0b wu=%0b wd=%0b run=%0d rev=%0d",
             $time, vld, do_clr, c, up_dnb, dir_vld, step_err, wrap_up, wrap_dn, run_len, rev_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #7;
    model_reset();
    vectors++;
    if (dut_vec !== exp_vec()) begin
      $display("FAIL reset: got %h expected %h", dut_vec, exp_vec());
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_count_up();
    cycle(1, 0, 1);
    for (int i = 0; i <= 5; i++) begin
      cycle(1, i, 0);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL count_up[%0d]: got %h expected %h", i, dut_vec, exp_vec());
        miscompares++;
      end
    end
    vectors++;
    if ({up_dnb, dir_vld, step_err, run_len, rev_cnt} !== {1'b1, 1'b1, 1'b0, 8'd5, 8'd0}) begin
      $display("FAIL count_up_final: up=%0b dv=%0b err=%0b run=%0d rev=%0d required 1 1 0 5 0",
               up_dnb, dir_vld, step_err, run_len, rev_cnt);
      miscompares++;
    end
  endtask

  task automatic test_reversals();
    int c;
    c = 8;
    cycle(1, 0, 1);
    cycle(1, c, 0);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 11; k++) begin
        c = (k < 6) ? (c + 1) % MODN : (c + MODN - 1) % MODN;
        cycle(1, c, 0);
        vectors++;
        if (dut_vec !== exp_vec()) begin
          $display("FAIL reversals[%0d.%0d]: got %h expected %h", r, k, dut_vec, exp_vec());
          miscompares++;
        end
      end
    end
    vectors++;
    if (rev_cnt !== 8'd5) begin
      $display("FAIL reversals_count: got %0d expected 5", rev_cnt);
      miscompares++;
    end
  endtask

  task automatic test_wrap();
    int seq [7] = '{14, 15, 0, 1, 1, 0, 15};
    int nwu, nwd;
    nwu = 0; nwd = 0;
    cycle(1, 0, 1);
    foreach (seq[i]) begin
      cycle(1, seq[i], 0);
      nwu += int'(wrap_up);
      nwd += int'(wrap_dn);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL wrap[%0d]: got %h expected %h", i, dut_vec, exp_vec());
        miscompares++;
      end
    end
    vectors++;
    if (nwu != 1 || nwd != 1) begin
      $display("FAIL wrap_counts: wrap_up=%0d wrap_dn=%0d expected 1 1", nwu, nwd);
      miscompares++;
    end
  endtask

  task automatic test_illegal();
    int seq [5] = '{3, 4, 5, 9, 10};
    cycle(1, 0, 1);
    foreach (seq[i]) begin
      cycle(1, seq[i], 0);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL illegal[%0d]: got %h expected %h", i, dut_vec, exp_vec());
        miscompares++;
      end
      if (i == 3) begin
        vectors++;
        if ({step_err, dir_vld, run_len} !== {1'b1, 1'b0, 8'd0}) begin
          $display("FAIL illegal_err: err=%0b dv=%0b run=%0d required 1 0 0", step_err, dir_vld, run_len);
          miscompares++;
        end
      end
    end
    vectors++;
    if ({up_dnb, dir_vld, run_len} !== {1'b1, 1'b1, 8'd1}) begin
      $display("FAIL illegal_recover: up=%0b dv=%0b run=%0d required 1 1 1", up_dnb, dir_vld, run_len);
      miscompares++;
    end
  endtask

  task automatic test_saturation_clr();
    cycle(1, 0, 1);
    for (int i = 0; i <= 300; i++) begin
      cycle(1, i % MODN, 0);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL saturate[%0d]: got %h expected %h", i, dut_vec, exp_vec());
        miscompares++;
      end
    end
    vectors++;
    if (run_len !== 8'd255) begin
      $display("FAIL saturate_final: got %0d expected 255", run_len);
      miscompares++;
    end
    cycle(1, 301 % MODN, 1);
    vectors++;
    if (dut_vec !== 21'd0) begin
      $display("FAIL clr: got %h expected 0", dut_vec);
      miscompares++;
    end
  endtask

  task automatic test_async_reset();
    int c;
    c = 5;
    cycle(1, 0, 1);
    cycle(1, c, 0);
    for (int k = 0; k < 4; k++) begin
      c = (c + MODN - 1) % MODN;
      cycle(1, c, 0);
    end
    vectors++;
    if (dut_vec !== exp_vec()) begin
      $display("FAIL async_pre: got %h expected %h", dut_vec, exp_vec());
      miscompares++;
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (dut_vec !== 21'd0) begin
      $display("FAIL async_reset: got %h expected 0", dut_vec);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
    // First sample after reset only primes the decoder.
    cycle(1, 9, 0);
    cycle(1, 8, 0);
    vectors++;
    if (dut_vec !== exp_vec()) begin
      $display("FAIL async_after: got %h expected %h", dut_vec, exp_vec());
      miscompares++;
    end
  endtask

  task automatic test_random();
    int r, c;
    cycle(1, 0, 1);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) cycle(1, int'($urandom_range(0, MODN - 1)), 1);
      else if (r < 3) cycle(0, int'($urandom_range(0, MODN - 1)), 0);
      else if (r < 5) cycle(1, int'($urandom_range(0, MODN - 1)), 0);
      else begin
        c = (r < 13) ? (m_prev + 1) % MODN : (m_prev + MODN - 1) % MODN;
        cycle(1, c, 0);
      end
      vectors++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, exp_vec());
        miscompares++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count_up();
    test_reversals();
    test_wrap();
    test_illegal();
    test_saturation_clr();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
